// File: rtl/sha1_shift.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_shift
//  Purpose  : SHA-1 message schedule generator. Holds a 16-word sliding
//             window of the most recent schedule words and produces W[t],
//             either passing the external message word through (load) or
//             computing rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
//  Ports    : clk    - single clock, rising-edge active
//             rst_n  - asynchronous active-low reset, clears the window
//             en     - 1: out = in (rounds 0..15); 0: out = computed word
//             in     - 32-bit message word, used only when en = 1
//             out    - 32-bit current schedule word W[t]
//  Config   : SHA1SHIFT_OUT_REG_EN - when defined, out is registered (one
//             cycle of latency); the window feedback still uses the
//             unregistered value, so the sequence is only delayed.
//  Revision : 1.0 - initial release
// ============================================================================
module sha1_shift (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] in,
   output logic [31:0] out
);

   // r_win[0] is W[t-1] (newest), r_win[15] is W[t-16] (oldest).
   logic [31:0] r_win [0:15];

   logic [31:0] w_mix;
   logic [31:0] w_calc;
   logic [31:0] w_next;

   always_comb begin
      w_mix  = r_win[2] ^ r_win[7] ^ r_win[13] ^ r_win[15];
      w_calc = {w_mix[30:0], w_mix[31]};
      w_next = en ? in : w_calc;
   end

   // Head of the window always takes the unregistered schedule word, so the
   // optional output register never changes the sequence itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win[0] <= 32'h0000_0000;
      end else begin
         r_win[0] <= w_next;
      end
   end

   // The window shifts every cycle; there is no stall.
   genvar gi;
   generate
      for (gi = 1; gi < 16; gi = gi + 1) begin : g_stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_win[gi] <= 32'h0000_0000;
            end else begin
               r_win[gi] <= r_win[gi-1];
            end
         end
      end
   endgenerate

`ifdef SHA1SHIFT_OUT_REG_EN
   logic [31:0] r_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 32'h0000_0000;
      end else begin
         r_out <= w_next;
      end
   end

   assign out = r_out;
`else
   assign out = w_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha1_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha1_shift
//  Purpose  : Self-checking bench for sha1_shift. Vectors are records of
//             {en, in, expected out} applied one per clock; expected words
//             come from hand-computed constants and a reference SHA-1
//             schedule computed from the 16 message words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_shift;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] in;
   logic [31:0] out;

   sha1_shift dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in    (in),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [0:79];
   logic [31:0] msg [0:15];
   logic [31:0] last_exp;
   int          checks;
   int          failures;

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   // Reference schedule: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
   task automatic fill_block();
      logic [31:0] w [0:79];
      for (int t = 0; t < 80; t++) begin
         if (t < 16) w[t] = msg[t];
         else        w[t] = rotl1(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16]);
         tbl[t].en  = (t < 16);
         tbl[t].din = (t < 16) ? msg[t] : 32'h0000_0000;
         tbl[t].exp = w[t];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // One vector per clock: drive after the falling edge, sample 1 ns later.
   // With the registered output, out shows the previous step's word.
   task automatic run_table(input int n, input string tag);
      logic [31:0] req;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en = tbl[i].en;
         in = tbl[i].din;
         #1;
`ifdef SHA1SHIFT_OUT_REG_EN
         req = last_exp;
`else
         req = tbl[i].exp;
`endif
         chk($sformatf("%s[%0d]", tag, i), out, req);
         last_exp = tbl[i].exp;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      last_exp = 32'h0000_0000;
      rst_n    = 1'b0;
      en       = 1'b0;
      in       = 32'h0000_0000;

      // Reset behaviour of the combinational output.
      #3;
      chk("reset_en0", out, 32'h0000_0000);
      en = 1'b1;
      in = 32'hDEAD_BEEF;
      #1;
`ifdef SHA1SHIFT_OUT_REG_EN
      chk("reset_en1", out, 32'h0000_0000);
`else
      chk("reset_en1", out, 32'hDEAD_BEEF);
`endif
      en = 1'b0;
      in = 32'h0000_0000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // SHA-1 "abc" block.
      for (int k = 0; k < 16; k++) msg[k] = 32'h0000_0000;
      msg[0]  = 32'h6162_6380;
      msg[15] = 32'h0000_0018;
      fill_block();
      tbl[16].exp = 32'hC2C4_C700;
      tbl[17].exp = 32'h0000_0000;
      tbl[18].exp = 32'h0000_0030;
      tbl[19].exp = 32'h8589_8E01;
      run_table(80, "abc");

      // Same block again, asynchronous reset at t=40.
      run_table(40, "abc_pre_rst");
      @(negedge clk);
      en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_immediate", out, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      last_exp = 32'h0000_0000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         en = 1'b0;
         #1;
         chk($sformatf("post_rst[%0d]", k), out, 32'h0000_0000);
      end
      last_exp = 32'h0000_0000;

      // Rotate MSB wrap: only the oldest word has bit 31 set.
      for (int k = 0; k < 16; k++) msg[k] = 32'h0000_0000;
      msg[0] = 32'h8000_0000;
      fill_block();
      tbl[16].exp = 32'h0000_0001;
      run_table(20, "msb_wrap");

      // Two back-to-back random blocks; second must not depend on the first.
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 16; k++) msg[k] = $urandom;
         fill_block();
         run_table(80, $sformatf("rand%0d", b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
